// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, redirect handling, registered IR and
// a bounded return-address stack with sticky overflow/underflow flags.
module fetch_unit #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned INS_W       = 19,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  input  logic [INS_W-1:0]  instruction,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch_taken,
  input  logic [7:0]        branch_offset,
  input  logic              call,
  input  logic              ret,
  output logic [INS_W-1:0]  ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  // sp counts 0..STACK_DEPTH inclusive; the index only spans the entries
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] branch_tgt;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_udf;

  // The memory sees the PC register only, never the redirect inputs
  assign address = pc;

  assign sp_dec     = sp - SP_W'(1);
  assign push_idx   = sp[IDX_W-1:0];
  assign pop_idx    = sp_dec[IDX_W-1:0];
  assign ret_addr   = ir_pc + ADDR_W'(1);
  assign branch_tgt = ir_pc + ADDR_W'($signed(branch_offset));

  // Redirect decode for the instruction held in ir; priority ret > call > jump > branch
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    set_ovf  = 1'b0;
    set_udf  = 1'b0;
    if (ir_valid && !stall) begin
      if (ret) begin
        redirect = 1'b1;
        if (sp == '0) begin
          set_udf = 1'b1;
        end else begin
          do_pop = 1'b1;
          target = stack[pop_idx];
        end
      end else if (call) begin
        redirect = 1'b1;
        target   = jump_addr;
        if (sp < SP_W'(STACK_DEPTH)) begin
          do_push = 1'b1;
        end else begin
          set_ovf = 1'b1;
        end
      end else if (jump) begin
        redirect = 1'b1;
        target   = jump_addr;
      end else if (branch_taken) begin
        redirect = 1'b1;
        target   = branch_tgt;
      end
    end
  end

  // PC, IR, stack pointer and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc              <= '0;
      ir              <= '0;
      ir_valid        <= 1'b0;
      ir_pc           <= '0;
      sp              <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      if (redirect) begin
        pc       <= target;
        ir       <= '0;
        ir_valid <= 1'b0;
      end else begin
        pc       <= pc + ADDR_W'(1);
        ir       <= instruction;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
      end
      if (do_push) begin
        sp <= sp + SP_W'(1);
      end else if (do_pop) begin
        sp <= sp_dec;
      end
      if (set_ovf) begin
        stack_overflow <= 1'b1;
      end
      if (set_udf) begin
        stack_underflow <= 1'b1;
      end
    end
  end

  // Return-address storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      stack[push_idx] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction memory.
module tb_fetch_unit;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned INS_W  = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] address;
  logic [INS_W-1:0]  instruction;
  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic              branch_taken;
  logic [7:0]        branch_offset;
  logic              call;
  logic              ret;
  logic [INS_W-1:0]  ir;
  logic              ir_valid;
  logic [ADDR_W-1:0] ir_pc;
  logic              stack_overflow;
  logic              stack_underflow;

  int tests  = 0;
  int failed = 0;

  fetch_unit #(.ADDR_W(12), .INS_W(19), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .address(address), .instruction(instruction),
    .stall(stall), .jump(jump), .jump_addr(jump_addr),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .call(call), .ret(ret), .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [INS_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {7'h2B, a};
  endfunction

  assign instruction = mem_word(address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input int pc_exp, input int irpc_exp);
    chk({tag, " address"}, 32'(address), 32'(pc_exp));
    chk({tag, " ir_valid"}, 32'(ir_valid), 32'd1);
    chk({tag, " ir_pc"}, 32'(ir_pc), 32'(irpc_exp));
    chk({tag, " ir"}, 32'(ir), 32'(mem_word(ADDR_W'(irpc_exp))));
  endtask

  task automatic chk_bubble(input string tag, input int pc_exp, input int sp_exp);
    chk({tag, " address"}, 32'(address), 32'(pc_exp));
    chk({tag, " ir_valid"}, 32'(ir_valid), 32'd0);
    chk({tag, " ir"}, 32'(ir), 32'd0);
    chk({tag, " sp"}, 32'(dut.sp), 32'(sp_exp));
  endtask

  initial begin
    int exp_tgt;
    rst = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0;
    branch_taken = 1'b0; branch_offset = '0; call = 1'b0; ret = 1'b0;

    // Reset values
    #2;
    chk("rst address", 32'(address), 32'd0);
    chk("rst ir", 32'(ir), 32'd0);
    chk("rst ir_valid", 32'(ir_valid), 32'd0);
    chk("rst ir_pc", 32'(ir_pc), 32'd0);
    chk("rst ovf", 32'(stack_overflow), 32'd0);
    chk("rst udf", 32'(stack_underflow), 32'd0);
    chk("rst sp", 32'(dut.sp), 32'd0);
    step();
    chk("rst held address", 32'(address), 32'd0);
    rst = 1'b1;

    // Sequential fetch: address 0..4, ir_pc 0..3
    chk("seq0 address", 32'(address), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_fetch($sformatf("seq%0d", k), k, k - 1);
    end

    // Call at ir_pc=3 to 100, ret ignored during the bubble
    call = 1'b1; jump_addr = 12'd100;
    step();
    chk_bubble("call", 100, 1);
    call = 1'b0; ret = 1'b1;
    step();
    chk_fetch("ret-in-bubble", 101, 100);
    chk("ret-in-bubble sp", 32'(dut.sp), 32'd1);
    ret = 1'b0;
    step();
    step();
    chk_fetch("pre-ret", 103, 102);
    ret = 1'b1;
    step();
    chk_bubble("ret", 4, 0);
    ret = 1'b0;
    step();
    chk_fetch("after-ret", 5, 4);

    // Jump to 10, then branch -5 from ir_pc=10
    jump = 1'b1; jump_addr = 12'd10;
    step();
    chk_bubble("jump", 10, 0);
    jump = 1'b0;
    step();
    chk_fetch("at10", 11, 10);
    branch_taken = 1'b1; branch_offset = 8'hFB;
    step();
    chk_bubble("branch", 5, 0);
    branch_taken = 1'b0;
    step();
    chk_fetch("after-branch", 6, 5);

    // Push 6 via call, then stalled jump+ret, then ret wins over jump
    call = 1'b1; jump_addr = 12'd300;
    step();
    chk_bubble("call300", 300, 1);
    call = 1'b0;
    step();
    chk_fetch("at300", 301, 300);
    stall = 1'b1; jump = 1'b1; ret = 1'b1; jump_addr = 12'd200;
    step();
    step();
    chk_fetch("stall", 301, 300);
    chk("stall sp", 32'(dut.sp), 32'd1);
    stall = 1'b0;
    step();
    chk_bubble("prio", 6, 0);
    jump = 1'b0; ret = 1'b0;
    step();
    chk_fetch("after-prio", 7, 6);
    chk("prio udf", 32'(stack_underflow), 32'd0);

    // Nine nested calls from ir_pc=6
    for (int i = 0; i < 9; i++) begin
      call = 1'b1; jump_addr = ADDR_W'(1000 + 10 * i);
      step();
      chk_bubble($sformatf("ncall%0d", i), 1000 + 10 * i, (i < 8) ? i + 1 : 8);
      chk($sformatf("ncall%0d ovf", i), 32'(stack_overflow), (i == 8) ? 32'd1 : 32'd0);
      call = 1'b0;
      step();
      chk_fetch($sformatf("ncall%0d land", i), 1000 + 10 * i + 1, 1000 + 10 * i);
    end

    // Nine returns: entries 1061,1051,...,1001,7 then underflow to 0
    for (int j = 0; j < 9; j++) begin
      if (j < 7) exp_tgt = 1000 + 10 * (6 - j) + 1;
      else if (j == 7) exp_tgt = 7;
      else exp_tgt = 0;
      ret = 1'b1;
      step();
      chk_bubble($sformatf("nret%0d", j), exp_tgt, (j < 8) ? 7 - j : 0);
      chk($sformatf("nret%0d udf", j), 32'(stack_underflow), (j == 8) ? 32'd1 : 32'd0);
      ret = 1'b0;
      step();
      chk_fetch($sformatf("nret%0d land", j), exp_tgt + 1, exp_tgt);
    end
    chk("sticky ovf", 32'(stack_overflow), 32'd1);

    // PC wrap from 4095 to 0
    jump = 1'b1; jump_addr = 12'd4095;
    step();
    chk_bubble("jump4095", 4095, 0);
    jump = 1'b0;
    step();
    chk_fetch("wrap", 0, 4095);
    step();
    chk_fetch("wrap+1", 1, 0);
    chk("wrap ovf", 32'(stack_overflow), 32'd1);
    chk("wrap udf", 32'(stack_underflow), 32'd1);

    // Asynchronous reset between edges with a redirect pending
    jump = 1'b1; jump_addr = 12'd50;
    #2;
    rst = 1'b0;
    #1;
    chk("arst address", 32'(address), 32'd0);
    chk("arst ir", 32'(ir), 32'd0);
    chk("arst ir_valid", 32'(ir_valid), 32'd0);
    chk("arst ir_pc", 32'(ir_pc), 32'd0);
    chk("arst ovf", 32'(stack_overflow), 32'd0);
    chk("arst udf", 32'(stack_underflow), 32'd0);
    chk("arst sp", 32'(dut.sp), 32'd0);
    step();
    chk("arst held address", 32'(address), 32'd0);
    chk("arst held ir_valid", 32'(ir_valid), 32'd0);
    jump = 1'b0;
    rst = 1'b1;
    step();
    chk_fetch("post-rst", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
